// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- sequential signed fixed-point divider (quot = num / denom)
//
// Operands and result are two's-complement with BIN_POS fractional bits.
// A restoring divider produces one quotient bit per clock on the magnitudes.
// A final cycle applies the sign and saturates the result. Each division is
// framed by a reset pulse: holding rst low clears the block, and the first
// rising edge with rst high captures the operands and starts the run.
//
// Parameters
//   DATA_WIDTH  total operand/result width, sign bit included
//   BIN_POS     number of fractional bits, 0 <= BIN_POS < DATA_WIDTH
//
// Ports
//   clk       in   1           clock, rising edge
//   rst       in   1           asynchronous active-low reset (low = clear)
//   ready     out  1           idle; num/denom captured on the next edge
//   complete  out  1           result valid, held until the next reset
//   num       in   DATA_WIDTH  signed dividend
//   denom     in   DATA_WIDTH  signed divisor
//   quot      out  DATA_WIDTH  signed quotient, same Q format as the inputs
//   div_zero  out  1           denom was zero; quot forced to 0
// -----------------------------------------------------------------------------
module div #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  complete,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic [DATA_WIDTH-1:0] denom,
  output logic [DATA_WIDTH-1:0] quot,
  output logic                  div_zero
);

  // The dividend is pre-shifted by BIN_POS so the integer quotient comes out
  // already in the operands' Q format.
  localparam int N     = DATA_WIDTH + BIN_POS;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Largest positive magnitude, and largest negative magnitude (2^(DW-1)).
  localparam logic [N-1:0] MAX_POS     = {{(BIN_POS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [N-1:0] MAX_NEG_MAG = MAX_POS + {{(N - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic                  sign;
  logic [DATA_WIDTH-1:0] abs_denom;
  logic [DATA_WIDTH-1:0] remainder;
  logic [N-1:0]          dividend;
  logic [N-1:0]          quotient;
  logic [CNT_W-1:0]      count;

  logic [DATA_WIDTH-1:0] abs_num;
  logic [DATA_WIDTH-1:0] abs_den_in;
  logic [N-1:0]          dividend_init;
  logic                  denom_is_zero;
  logic [DATA_WIDTH:0]   rem_shift;
  logic                  rem_ge;
  logic [DATA_WIDTH-1:0] rem_diff;
  logic [DATA_WIDTH-1:0] mag_low;
  logic [DATA_WIDTH-1:0] fix_result;

  // Operand magnitudes. -2^(DW-1) negates to itself, and that bit pattern is
  // exactly 2^(DW-1) when read as unsigned, so no special case is needed.
  always_comb begin
    abs_num       = num[DATA_WIDTH-1] ? -num : num;
    abs_den_in    = denom[DATA_WIDTH-1] ? -denom : denom;
    denom_is_zero = (denom == '0);
    dividend_init = '0;
    dividend_init[DATA_WIDTH-1:0] = abs_num;
    dividend_init = dividend_init << BIN_POS;
  end

  // One restoring step. The remainder register stays below |denom| and fits
  // in DATA_WIDTH bits. Only the shifted value needs the extra bit. When
  // the subtraction happens the difference is below 2^DW, so the low
  // DATA_WIDTH bits of the modular subtraction are exact.
  always_comb begin
    rem_shift = {remainder, dividend[N-1]};
    rem_ge    = (rem_shift >= {1'b0, abs_denom});
    rem_diff  = rem_shift[DATA_WIDTH-1:0] - abs_denom;
  end

  // Sign application with saturation. The negative side allows one more LSB
  // of magnitude than the positive side.
  always_comb begin
    mag_low    = quotient[DATA_WIDTH-1:0];
    fix_result = '0;
    if (!sign) begin
      fix_result = (quotient > MAX_POS) ? {1'b0, {(DATA_WIDTH - 1){1'b1}}} : mag_low;
    end else begin
      fix_result = (quotient > MAX_NEG_MAG) ? {1'b1, {(DATA_WIDTH - 1){1'b0}}} : -mag_low;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        ready      = 1'b1;
        state_next = denom_is_zero ? DONE : CALC;
      end
      CALC: begin
        if (count == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        complete = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Operands are sampled only when leaving IDLE. Nothing is written
  // in DONE, so the result is held until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign      <= 1'b0;
      abs_denom <= '0;
      remainder <= '0;
      dividend  <= '0;
      quotient  <= '0;
      count     <= '0;
      quot      <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sign      <= num[DATA_WIDTH-1] ^ denom[DATA_WIDTH-1];
          abs_denom <= abs_den_in;
          dividend  <= dividend_init;
          remainder <= '0;
          quotient  <= '0;
          count     <= '0;
          quot      <= '0;
          div_zero  <= denom_is_zero;
        end
        CALC: begin
          dividend  <= {dividend[N-2:0], 1'b0};
          remainder <= rem_ge ? rem_diff : rem_shift[DATA_WIDTH-1:0];
          quotient  <= {quotient[N-2:0], rem_ge};
          count     <= count + 1'b1;
        end
        FIX: begin
          quot <= fix_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- self-checking bench for div (DATA_WIDTH=32, BIN_POS=16)
//
// Each division is framed by a reset pulse. The expected result and latency
// are queued when a division is launched. They are popped and compared once
// complete rises. Directed vectors use hand-derived constants. Random vectors
// use a 64-bit integer reference that truncates toward zero and saturates.
// -----------------------------------------------------------------------------
module tb_div;

  localparam int DW = 32;
  localparam int BP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready;
  logic          complete;
  logic [DW-1:0] num = '0;
  logic [DW-1:0] denom = '0;
  logic [DW-1:0] quot;
  logic          div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] q;
    logic          dz;
    int            lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  div #(
    .DATA_WIDTH(DW),
    .BIN_POS   (BP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .complete(complete),
    .num     (num),
    .denom   (denom),
    .quot    (quot),
    .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: (num * 2^BP) / denom with truncation toward zero, then saturate.
  function automatic logic [DW-1:0] model_q(input logic [DW-1:0] n, input logic [DW-1:0] d);
    longint a;
    longint b;
    longint q;
    a = longint'($signed(n)) * (64'sd1 <<< BP);
    b = longint'($signed(d));
    if (b == 0) return '0;
    q = a / b;
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    if (q < -64'sd2147483648) q = -64'sd2147483648;
    return q[DW-1:0];
  endfunction

  // Hold reset with the new operands applied, check the cleared outputs, queue
  // the expectation, then release reset to launch the division.
  task automatic apply_stimulus(input string tag, input logic [DW-1:0] n, input logic [DW-1:0] d,
                                input logic [DW-1:0] eq, input logic edz, input int elat);
    exp_t e;
    @(negedge clk);
    rst   = 1'b0;
    num   = n;
    denom = d;
    #1;
    check({tag, "_rst_ready"}, 64'(ready), 64'(1'b1));
    check({tag, "_rst_complete"}, 64'(complete), 64'(1'b0));
    check({tag, "_rst_quot"}, 64'(quot), 64'(0));
    check({tag, "_rst_dz"}, 64'(div_zero), 64'(1'b0));
    e.q   = eq;
    e.dz  = edz;
    e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_output(input string tag);
    int   edges;
    int   overlap;
    bit   seen;
    exp_t e;
    edges   = 0;
    overlap = 0;
    seen    = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (ready && complete) overlap++;
      // Operands change after capture and must not disturb the result.
      if (edges == 3) begin
        num   = $urandom;
        denom = $urandom;
      end
      if (complete) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'(1'b1));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(edges), 64'(e.lat));
      check({tag, "_quot"}, 64'(quot), 64'(e.q));
      check({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
      check({tag, "_ready_low"}, 64'(ready), 64'(1'b0));
      check({tag, "_no_overlap"}, 64'(overlap), 64'(0));
      num   = ~num;
      denom = ~denom;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold_quot"}, 64'(quot), 64'(e.q));
      check({tag, "_hold_complete"}, 64'(complete), 64'(1'b1));
    end
  endtask

  task automatic run(input string tag, input logic [DW-1:0] n, input logic [DW-1:0] d,
                     input logic [DW-1:0] eq, input logic edz);
    apply_stimulus(tag, n, d, eq, edz, (d == '0) ? 1 : DW + BP + 2);
    check_output(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [DW-1:0] rn;
    logic [DW-1:0] rd;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'(1'b1));
    check("reset_complete", 64'(complete), 64'(1'b0));
    check("reset_quot", 64'(quot), 64'(0));
    check("reset_dz", 64'(div_zero), 64'(1'b0));

    run("six_by_two",   32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
    run("m7p5_by_2p5",  32'hFFF8_8000, 32'h0002_8000, 32'hFFFD_0000, 1'b0);
    run("7p5_by_m2p5",  32'h0007_8000, 32'hFFFD_8000, 32'hFFFD_0000, 1'b0);
    run("m7p5_by_m2p5", 32'hFFF8_8000, 32'hFFFD_8000, 32'h0003_0000, 1'b0);
    run("one_third",    32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0);
    run("m_one_third",  32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0);
    run("div_zero",     32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    run("zero_zero",    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    run("zero_num",     32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0);
    run("sat_pos",      32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
    run("sat_neg",      32'h8001_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
    run("min_num",      32'h8000_0000, 32'h0002_0000, 32'hC000_0000, 1'b0);
    run("min_denom",    32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFE, 1'b0);
    run("exact_min",    32'hC000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0);

    // Abort a division ten cycles into CALC with an asynchronous reset.
    @(negedge clk);
    rst   = 1'b0;
    num   = 32'h0006_0000;
    denom = 32'h0002_0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    check("abort_busy_ready", 64'(ready), 64'(1'b0));
    check("abort_busy_complete", 64'(complete), 64'(1'b0));
    rst = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'(1'b1));
    check("abort_complete", 64'(complete), 64'(1'b0));
    check("abort_quot", 64'(quot), 64'(0));
    check("abort_dz", 64'(div_zero), 64'(1'b0));
    run("after_abort", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rn = $urandom;
      rd = $urandom;
      if (i % 2 == 0) rd = {{12{rd[DW-1]}}, rd[19:0]};
      run($sformatf("rand%0d", i), rn, rd, model_q(rn, rd), (rd == '0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
